ulpi_reg_ctrl: RTL and testbench
================================

Name: ulpi_reg_ctrl

Overview:
- Sequences and shares the ULPI PHY register-access port (REG_EN/REG_RW/REG_ADDR/REG_DATA_I → REG_DONE/REG_FAIL/REG_DATA_O).
- After reset and PHY READY, it writes a fixed init table to the PHY and verifies each entry by read-back, with retries.
- It then arbitrates register accesses from two client requesters, round-robin, one access in flight at a time.
- Sits between the ULPI wrapper and the USB device-control logic.

Parameters:
RETRY_MAX, 3, attempts per init entry (write plus verify) before declaring init error
TIMEOUT, 200, cycles from REG_EN pulse to REG_DONE/REG_FAIL before the access counts as failed (8-bit counter, 1..255)

Ports:
CLK_60M  in  1  60 MHz ULPI clock
RST_USB  in  1  synchronous, active-high reset
READY  in  1  ULPI wrapper ready for register operations
REG_EN  out  1  one-cycle strobe requesting a register operation
REG_RW  out  1  1 = write, 0 = read
REG_ADDR  out  6  PHY register address
REG_DATA_I  out  8  write data to PHY
REG_DATA_O  in  8  read data; valid in the cycle REG_DONE=1 on a read
REG_DONE  in  1  operation complete (single-cycle)
REG_FAIL  in  1  operation aborted by PHY (single-cycle)
CLI_REQ  in  2  per-client request level; bit i = client i
CLI_RW  in  2  per-client direction
CLI_ADDR  in  12  client i address at [6i+5:6i]
CLI_WDATA  in  16  client i write data at [8i+7:8i]
CLI_DONE  out  2  one-cycle success pulse to the served client
CLI_FAIL  out  2  one-cycle failure pulse to the served client
CLI_RDATA  out  8  read data, valid while CLI_DONE pulses
INIT_DONE  out  1  init table written and verified (sticky until reset)
INIT_ERR  out  1  an init entry exhausted RETRY_MAX (sticky until reset)

Behaviour:
- Reset values:
  - All outputs 0. CLI_RDATA = 0x00.
  - State WAIT_RDY, entry index 0, retry count 0, round-robin pointer last = 1 (client 0 wins first tie).
- Init table, fixed, in order:
  - 0: addr 0x04, data 0x45 (Function Control: FS, TermSelect, SuspendM)
  - 1: addr 0x0A, data 0x00 (OTG Control)
  - 2: addr 0x07, data 0x00 (Interface Control)
- Issue rule:
  - REG_EN is high for exactly one cycle, and only when READY=1 in that cycle.
  - REG_RW, REG_ADDR and REG_DATA_I are driven in the REG_EN cycle and held stable until the access completes.
  - Timeout counter clears at REG_EN and increments each cycle after it.
- Completion priority in any wait state, checked each cycle:
  1. REG_DONE → success
  2. REG_FAIL → fail
  3. READY=0 → fail (PHY reset mid-op)
  4. counter == TIMEOUT → fail
- States and transitions:
  - WAIT_RDY: wait for READY=1 → INIT_WR.
  - INIT_WR: issue write of entry[idx] → INIT_WR_W.
  - INIT_WR_W: success → INIT_RD; fail → RETRY.
  - INIT_RD: issue read of entry[idx].addr → INIT_RD_W.
  - INIT_RD_W:
    - success with REG_DATA_O == entry data → idx+1, retry count cleared; after idx 2 → INIT_DONE=1, go to ARB.
    - mismatch or fail → RETRY.
  - RETRY:
    - retry count +1; if it reaches RETRY_MAX → INIT_ERR=1, go to ARB.
    - otherwise wait for READY, then INIT_WR of the same entry.
  - ARB: entered only with INIT_DONE or INIT_ERR set.
    - Pick a client when READY=1 and any CLI_REQ bit is set.
    - If both request, grant the client != last; update last to the granted client.
    - Latch the granted client's RW, ADDR and WDATA → CLI_ISSUE.
  - CLI_ISSUE: issue → CLI_W.
  - CLI_W:
    - success → CLI_DONE[g] pulse; CLI_RDATA = REG_DATA_O on a read, else hold.
    - fail → CLI_FAIL[g] pulse.
    - Both cases then go to ARB_HOLD.
  - ARB_HOLD: one cycle, so the client can drop REQ; → ARB.
- Client rules:
  - REQ and operands are held stable from assertion until DONE/FAIL; REQ is deasserted in the cycle after the pulse.
  - No client access is issued before INIT_DONE or INIT_ERR.
  - At most one DONE/FAIL bit is high in any cycle. No retries for client accesses.
- A client write to 0x04 with bit5 set (PHY reset):
  - Reported as done on REG_DONE.
  - The following ARB waits for READY to rise again before the next issue.
  - INIT_DONE stays set; no re-init.
- Simultaneous REG_DONE and REG_FAIL: DONE wins.
- REG_DONE/REG_FAIL outside a wait state: ignored.
- Reset asserted mid-operation: returns to WAIT_RDY next edge, init re-runs, and no pulse is emitted for the aborted access.

Test Plan:
- Nominal init: READY rises 5 cycles after reset release; the PHY model returns DONE 4 cycles after each REG_EN and echoes written data → exactly 6 REG_EN pulses, addresses 0x04, 0x04, 0x0A, 0x0A, 0x07, 0x07 with RW 1, 0, 1, 0, 1, 0; INIT_DONE=1, INIT_ERR=0.
- Verify mismatch: the model returns 0x44 on the first read of 0x04 → entry 0 rewritten once, then passes; 8 REG_EN pulses in total; INIT_DONE=1.
- Persistent failure: the model answers every op on 0x0A with REG_FAIL → 3 write attempts on 0x0A, then INIT_ERR=1, INIT_DONE=0; a client read of 0x00 is then served.
- Timeout: the model never responds to the first write → after 200 cycles with no REG_DONE/REG_FAIL the write of 0x04 is reissued; no REG_EN while READY=0.
- Arbitration: both clients request continuously after init (client 0 reads 0x00, client 1 writes 0x16=0xA5) → grants alternate 0, 1, 0, 1; client 0 gets CLI_DONE[0] with CLI_RDATA=0x24 from the model; never two pulses in one cycle.
- PHY reset mid-op: READY drops 2 cycles after a client REG_EN → CLI_FAIL for that client; no further REG_EN until READY=1; RST_USB pulse mid-init restarts the sequence at addr 0x04.

Source files
------------

// File: rtl/ulpi_reg_ctrl_if.sv
// ulpi_reg_ctrl_if
// Register-access port between the ULPI wrapper and ulpi_reg_ctrl.
//   READY      : wrapper ready for register operations (wrapper -> ctrl)
//   REG_EN     : one-cycle request strobe               (ctrl -> wrapper)
//   REG_RW     : 1 = write, 0 = read                    (ctrl -> wrapper)
//   REG_ADDR   : PHY register address                   (ctrl -> wrapper)
//   REG_DATA_I : write data                             (ctrl -> wrapper)
//   REG_DATA_O : read data, valid with REG_DONE         (wrapper -> ctrl)
//   REG_DONE   : access complete, single cycle          (wrapper -> ctrl)
//   REG_FAIL   : access aborted, single cycle           (wrapper -> ctrl)
// master = controller side, slave = wrapper/PHY side.
interface ulpi_reg_ctrl_if;
    logic       READY;
    logic       REG_EN;
    logic       REG_RW;
    logic [5:0] REG_ADDR;
    logic [7:0] REG_DATA_I;
    logic [7:0] REG_DATA_O;
    logic       REG_DONE;
    logic       REG_FAIL;

    modport master (
        input  READY, REG_DATA_O, REG_DONE, REG_FAIL,
        output REG_EN, REG_RW, REG_ADDR, REG_DATA_I
    );

    modport slave (
        output READY, REG_DATA_O, REG_DONE, REG_FAIL,
        input  REG_EN, REG_RW, REG_ADDR, REG_DATA_I
    );
endinterface

// File: rtl/ulpi_reg_ctrl.sv
// ulpi_reg_ctrl
// Owns the ULPI PHY register port: after reset and READY it writes and
// read-back-verifies a fixed init table (with retries), then serves two
// client requesters round-robin, one access in flight.
//   CLK_60M   : ULPI clock
//   RST_USB   : synchronous active-high reset
//   phy       : register-access port (master side)
//   CLI_REQ/CLI_RW/CLI_ADDR/CLI_WDATA : client i request, fields at slice i
//   CLI_DONE/CLI_FAIL : one-cycle completion pulse to the served client
//   CLI_RDATA : read data, valid while CLI_DONE pulses
//   INIT_DONE / INIT_ERR : sticky init outcome
//
// state     | meaning
// WAIT_RDY  | after reset, waiting for READY
// INIT_WR   | issue write of init entry idx
// INIT_WR_W | wait for init write completion
// INIT_RD   | issue read-back of init entry idx
// INIT_RD_W | wait for read-back, compare data
// RETRY     | count a failed attempt, give up at RETRY_MAX
// ARB       | pick next client (round-robin)
// CLI_ISSUE | issue latched client access
// CLI_W     | wait for client access completion
// ARB_HOLD  | one idle cycle so the served client can drop REQ
module ulpi_reg_ctrl #(
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic            CLK_60M,
    input  logic            RST_USB,
    ulpi_reg_ctrl_if.master phy,
    input  logic [1:0]      CLI_REQ,
    input  logic [1:0]      CLI_RW,
    input  logic [11:0]     CLI_ADDR,
    input  logic [15:0]     CLI_WDATA,
    output logic [1:0]      CLI_DONE,
    output logic [1:0]      CLI_FAIL,
    output logic [7:0]      CLI_RDATA,
    output logic            INIT_DONE,
    output logic            INIT_ERR
);

    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);
    localparam logic [3:0] RMAX   = 4'(RETRY_MAX);

    typedef enum logic [3:0] {
        WAIT_RDY, INIT_WR, INIT_WR_W, INIT_RD, INIT_RD_W,
        RETRY, ARB, CLI_ISSUE, CLI_W, ARB_HOLD
    } state_t;

    state_t     state, state_nx;
    logic [1:0] idx;
    logic [3:0] retry_cnt, retry_nx;
    logic [7:0] to_cnt;
    logic       last, grant;
    logic       c_g, c_rw;
    logic [5:0] c_addr;
    logic [7:0] c_wdata;
    logic       rst_pend;
    logic [5:0] ent_addr;
    logic [7:0] ent_data;
    logic       cmpl_ok, cmpl_fail;
    logic       reg_en, reg_rw;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;

    always_comb begin
        case (idx)
            2'd0:    begin ent_addr = 6'h04; ent_data = 8'h45; end
            2'd1:    begin ent_addr = 6'h0A; ent_data = 8'h00; end
            default: begin ent_addr = 6'h07; ent_data = 8'h00; end
        endcase
    end

    assign phy.REG_EN     = reg_en;
    assign phy.REG_RW     = reg_rw;
    assign phy.REG_ADDR   = reg_addr;
    assign phy.REG_DATA_I = reg_wdata;

    always_comb begin
        state_nx  = state;
        reg_en    = 1'b0;
        reg_rw    = 1'b0;
        reg_addr  = 6'h00;
        reg_wdata = 8'h00;
        retry_nx  = retry_cnt + 4'd1;
        // DONE beats FAIL; a READY drop means the PHY went into reset.
        cmpl_ok   = phy.REG_DONE;
        cmpl_fail = !phy.REG_DONE &&
                    (phy.REG_FAIL || !phy.READY || to_cnt == TO_VAL);
        grant     = (CLI_REQ == 2'b11) ? ~last : CLI_REQ[1];
        case (state)
            WAIT_RDY: if (phy.READY) state_nx = INIT_WR;
            INIT_WR: begin
                reg_rw = 1'b1; reg_addr = ent_addr; reg_wdata = ent_data;
                if (phy.READY) begin
                    reg_en   = 1'b1;
                    state_nx = INIT_WR_W;
                end
            end
            INIT_WR_W: begin
                reg_rw = 1'b1; reg_addr = ent_addr; reg_wdata = ent_data;
                if (cmpl_ok)        state_nx = INIT_RD;
                else if (cmpl_fail) state_nx = RETRY;
            end
            INIT_RD: begin
                reg_addr = ent_addr; reg_wdata = ent_data;
                if (phy.READY) begin
                    reg_en   = 1'b1;
                    state_nx = INIT_RD_W;
                end
            end
            INIT_RD_W: begin
                reg_addr = ent_addr; reg_wdata = ent_data;
                if (cmpl_ok && phy.REG_DATA_O == ent_data)
                    state_nx = (idx == 2'd2) ? ARB : INIT_WR;
                else if (cmpl_ok || cmpl_fail)
                    state_nx = RETRY;
            end
            RETRY: state_nx = (retry_nx >= RMAX) ? ARB : INIT_WR;
            ARB: if (phy.READY && !rst_pend && |CLI_REQ) state_nx = CLI_ISSUE;
            CLI_ISSUE: begin
                reg_rw = c_rw; reg_addr = c_addr; reg_wdata = c_wdata;
                if (phy.READY) begin
                    reg_en   = 1'b1;
                    state_nx = CLI_W;
                end
            end
            CLI_W: begin
                reg_rw = c_rw; reg_addr = c_addr; reg_wdata = c_wdata;
                if (cmpl_ok || cmpl_fail) state_nx = ARB_HOLD;
            end
            ARB_HOLD: state_nx = ARB;
            default:  state_nx = WAIT_RDY;
        endcase
    end

    always_ff @(posedge CLK_60M) begin
        if (RST_USB) begin
            state     <= WAIT_RDY;
            idx       <= 2'd0;
            retry_cnt <= 4'd0;
            to_cnt    <= 8'd0;
            last      <= 1'b1;
            c_g       <= 1'b0;
            c_rw      <= 1'b0;
            c_addr    <= 6'h00;
            c_wdata   <= 8'h00;
            rst_pend  <= 1'b0;
            CLI_DONE  <= 2'b00;
            CLI_FAIL  <= 2'b00;
            CLI_RDATA <= 8'h00;
            INIT_DONE <= 1'b0;
            INIT_ERR  <= 1'b0;
        end else begin
            state    <= state_nx;
            CLI_DONE <= 2'b00;
            CLI_FAIL <= 2'b00;
            if (reg_en)
                to_cnt <= 8'd0;
            else if (to_cnt != 8'hFF)
                to_cnt <= to_cnt + 8'd1;
            // A PHY-reset write is only followed up once READY has dropped.
            if (!phy.READY)
                rst_pend <= 1'b0;
            case (state)
                INIT_RD_W: begin
                    if (cmpl_ok && phy.REG_DATA_O == ent_data) begin
                        idx       <= idx + 2'd1;
                        retry_cnt <= 4'd0;
                        if (idx == 2'd2)
                            INIT_DONE <= 1'b1;
                    end
                end
                RETRY: begin
                    if (retry_nx >= RMAX)
                        INIT_ERR <= 1'b1;
                    else
                        retry_cnt <= retry_nx;
                end
                ARB: begin
                    if (state_nx == CLI_ISSUE) begin
                        c_g     <= grant;
                        last    <= grant;
                        c_rw    <= CLI_RW[grant];
                        c_addr  <= grant ? CLI_ADDR[11:6] : CLI_ADDR[5:0];
                        c_wdata <= grant ? CLI_WDATA[15:8] : CLI_WDATA[7:0];
                    end
                end
                CLI_W: begin
                    if (cmpl_ok) begin
                        CLI_DONE[c_g] <= 1'b1;
                        if (!c_rw)
                            CLI_RDATA <= phy.REG_DATA_O;
                        if (c_rw && c_addr == 6'h04 && c_wdata[5])
                            rst_pend <= 1'b1;
                    end else if (cmpl_fail) begin
                        CLI_FAIL[c_g] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// tb_ulpi_reg_ctrl
// Directed bench for ulpi_reg_ctrl: a PHY model answers register accesses,
// expected REG_EN accesses and client completions are queued as stimulus is
// set up and compared as the DUT produces them.
module tb_ulpi_reg_ctrl;

    typedef struct {
        logic       id;
        logic       ok;
        logic       chk_rd;
        logic [7:0] rd;
    } cli_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, rw0, rw1;
    logic [5:0]  addr0, addr1;
    logic [7:0]  wd0, wd1;
    logic [1:0]  CLI_DONE, CLI_FAIL;
    logic [7:0]  CLI_RDATA;
    logic        INIT_DONE, INIT_ERR;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int en_cnt = 0;
    int en_t[$];
    logic [6:0] exp_en[$];
    cli_exp_t   exp_cli[$];

    // PHY model controls
    logic mis_first_04 = 1'b0;
    logic fail_0a      = 1'b0;
    logic drop_first_wr = 1'b0;
    logic mute         = 1'b0;
    logic [7:0] regs [64];
    int   pend = 0;
    logic p_rw, p_fail;
    logic [5:0] p_a;
    logic [7:0] p_d;

    ulpi_reg_ctrl_if bus ();

    ulpi_reg_ctrl dut (
        .CLK_60M   (clk),
        .RST_USB   (rst),
        .phy       (bus),
        .CLI_REQ   ({req1, req0}),
        .CLI_RW    ({rw1, rw0}),
        .CLI_ADDR  ({addr1, addr0}),
        .CLI_WDATA ({wd1, wd0}),
        .CLI_DONE  (CLI_DONE),
        .CLI_FAIL  (CLI_FAIL),
        .CLI_RDATA (CLI_RDATA),
        .INIT_DONE (INIT_DONE),
        .INIT_ERR  (INIT_ERR)
    );

    always #8 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // PHY model: answers 4 cycles after REG_EN, echoes written data.
    always @(negedge clk) begin
        bus.REG_DONE = 1'b0;
        bus.REG_FAIL = 1'b0;
        if (rst) begin
            pend = 0;
            for (int i = 0; i < 64; i++) regs[i] = 8'h00;
            regs[0] = 8'h24;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (p_fail) begin
                        bus.REG_FAIL = 1'b1;
                    end else begin
                        bus.REG_DONE = 1'b1;
                        if (p_rw) begin
                            regs[p_a] = p_d;
                        end else begin
                            bus.REG_DATA_O = regs[p_a];
                            if (mis_first_04 && p_a == 6'h04) begin
                                bus.REG_DATA_O = 8'h44;
                                mis_first_04 = 1'b0;
                            end
                        end
                    end
                end
            end
            if (bus.REG_EN) begin
                p_rw   = bus.REG_RW;
                p_a    = bus.REG_ADDR;
                p_d    = bus.REG_DATA_I;
                p_fail = fail_0a && bus.REG_ADDR == 6'h0A;
                pend   = 4;
                if (mute) pend = 0;
                if (drop_first_wr && bus.REG_RW) begin
                    drop_first_wr = 1'b0;
                    pend = 0;
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [6:0] e;
        cli_exp_t   ce;
        if (bus.REG_EN) begin
            en_cnt++;
            en_t.push_back(cyc_n);
            chk("en_ready", bus.READY, 1);
            chk("en_expected", exp_en.size() != 0, 1);
            if (exp_en.size() != 0) begin
                e = exp_en.pop_front();
                chk("en_rw", bus.REG_RW, e[6]);
                chk("en_addr", bus.REG_ADDR, e[5:0]);
            end
        end
        if (|{CLI_DONE, CLI_FAIL}) begin
            chk("pulse_onehot", $countones({CLI_DONE, CLI_FAIL}), 1);
            chk("cli_expected", exp_cli.size() != 0, 1);
            if (exp_cli.size() != 0) begin
                ce = exp_cli.pop_front();
                chk("cli_id", CLI_DONE[1] | CLI_FAIL[1], ce.id);
                chk("cli_ok", |CLI_DONE, ce.ok);
                if (ce.ok && ce.chk_rd) chk("cli_rdata", CLI_RDATA, ce.rd);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pe(input logic rw, input logic [5:0] a);
        exp_en.push_back({rw, a});
    endtask

    task automatic pc(input logic id, input logic ok, input logic cr, input logic [7:0] rd);
        cli_exp_t c;
        c.id = id; c.ok = ok; c.chk_rd = cr; c.rd = rd;
        exp_cli.push_back(c);
    endtask

    task automatic push_nominal();
        pe(1, 6'h04); pe(0, 6'h04);
        pe(1, 6'h0A); pe(0, 6'h0A);
        pe(1, 6'h07); pe(0, 6'h07);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.READY = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        cyc(2);
        exp_en.delete();
        exp_cli.delete();
        en_t.delete();
        en_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic wait_init(input string tag, input int lim);
        int t = 0;
        while (!(INIT_DONE || INIT_ERR) && t < lim) begin
            cyc(1);
            t++;
        end
        chk(tag, t < lim, 1);
    endtask

    task automatic wait_drop(input int i, input int lim);
        int t = 0;
        while (!(CLI_DONE[i] || CLI_FAIL[i]) && t < lim) begin
            cyc(1);
            t++;
        end
        chk("cli_wait", t < lim, 1);
        cyc(1);
        if (i == 0) req0 = 1'b0; else req1 = 1'b0;
        cyc(1);
    endtask

    task automatic client_ops(input int i, input int n, input logic rw,
                              input logic [5:0] a, input logic [7:0] d);
        for (int k = 0; k < n; k++) begin
            if (i == 0) begin rw0 = rw; addr0 = a; wd0 = d; req0 = 1'b1; end
            else        begin rw1 = rw; addr1 = a; wd1 = d; req1 = 1'b1; end
            wait_drop(i, 100);
        end
    endtask

    initial begin
        int gap;
        rst = 1'b1;
        bus.READY = 1'b0;
        bus.REG_DATA_O = 8'h00;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0;
        cyc(3);

        // reset state
        chk("rst_en", bus.REG_EN, 0);
        chk("rst_rw", bus.REG_RW, 0);
        chk("rst_addr", bus.REG_ADDR, 0);
        chk("rst_wdata", bus.REG_DATA_I, 0);
        chk("rst_done", CLI_DONE, 0);
        chk("rst_fail", CLI_FAIL, 0);
        chk("rst_rdata", CLI_RDATA, 0);
        chk("rst_init_done", INIT_DONE, 0);
        chk("rst_init_err", INIT_ERR, 0);

        // nominal init
        do_reset();
        push_nominal();
        cyc(5);
        bus.READY = 1'b1;
        wait_init("nom_init_wait", 500);
        cyc(3);
        chk("nom_init_done", INIT_DONE, 1);
        chk("nom_init_err", INIT_ERR, 0);
        chk("nom_en_cnt", en_cnt, 6);

        // read-back mismatch on entry 0; a client request pending during init
        do_reset();
        mis_first_04 = 1'b1;
        pe(1, 6'h04); pe(0, 6'h04);
        push_nominal();
        pe(0, 6'h00);
        pc(0, 1, 1, 8'h24);
        rw0 = 1'b0; addr0 = 6'h00; req0 = 1'b1;
        cyc(5);
        bus.READY = 1'b1;
        wait_init("mis_init_wait", 500);
        chk("mis_en_cnt_init", en_cnt, 8);
        chk("mis_init_done", INIT_DONE, 1);
        wait_drop(0, 100);
        chk("mis_en_cnt", en_cnt, 9);

        // persistent failure on 0x0A
        do_reset();
        fail_0a = 1'b1;
        pe(1, 6'h04); pe(0, 6'h04);
        pe(1, 6'h0A); pe(1, 6'h0A); pe(1, 6'h0A);
        cyc(5);
        bus.READY = 1'b1;
        wait_init("err_init_wait", 500);
        cyc(2);
        chk("err_init_err", INIT_ERR, 1);
        chk("err_init_done", INIT_DONE, 0);
        chk("err_en_cnt", en_cnt, 5);
        fail_0a = 1'b0;
        pe(0, 6'h00);
        pc(0, 1, 1, 8'h24);
        client_ops(0, 1, 0, 6'h00, 8'h00);
        chk("err_q_empty", exp_en.size() + exp_cli.size(), 0);

        // timeout on first write
        do_reset();
        drop_first_wr = 1'b1;
        pe(1, 6'h04);
        push_nominal();
        cyc(5);
        bus.READY = 1'b1;
        wait_init("to_init_wait", 800);
        chk("to_init_done", INIT_DONE, 1);
        chk("to_en_cnt", en_cnt, 7);
        gap = (en_t.size() >= 2) ? en_t[1] - en_t[0] : 0;
        chk("to_gap_lo", gap >= 200, 1);
        chk("to_gap_hi", gap <= 210, 1);

        // arbitration
        do_reset();
        push_nominal();
        cyc(5);
        bus.READY = 1'b1;
        wait_init("arb_init_wait", 500);
        pe(0, 6'h00); pe(1, 6'h16); pe(0, 6'h00); pe(1, 6'h16);
        pc(0, 1, 1, 8'h24); pc(1, 1, 1, 8'h24);
        pc(0, 1, 1, 8'h24); pc(1, 1, 1, 8'h24);
        fork
            client_ops(0, 2, 0, 6'h00, 8'h00);
            client_ops(1, 2, 1, 6'h16, 8'hA5);
        join
        pe(0, 6'h00);
        pc(0, 1, 1, 8'h24);
        client_ops(0, 1, 0, 6'h00, 8'h00);
        // last served is client 0, so a tie now goes to client 1
        pe(1, 6'h16); pe(0, 6'h00);
        pc(1, 1, 1, 8'h24); pc(0, 1, 1, 8'h24);
        fork
            client_ops(0, 1, 0, 6'h00, 8'h00);
            client_ops(1, 1, 1, 6'h16, 8'hA5);
        join
        chk("arb_en_cnt", en_cnt, 13);
        chk("arb_phy_wr", regs[6'h16], 8'hA5);
        chk("arb_q_empty", exp_en.size() + exp_cli.size(), 0);

        // PHY reset mid client access
        do_reset();
        push_nominal();
        cyc(5);
        bus.READY = 1'b1;
        wait_init("prst_init_wait", 500);
        mute = 1'b1;
        pe(0, 6'h00);
        pc(0, 0, 0, 8'h00);
        rw0 = 1'b0; addr0 = 6'h00; req0 = 1'b1;
        begin
            int t = 0;
            while (en_cnt < 7 && t < 50) begin cyc(1); t++; end
            chk("prst_en_wait", t < 50, 1);
        end
        cyc(2);
        bus.READY = 1'b0;
        wait_drop(0, 50);
        mute = 1'b0;
        rw1 = 1'b1; addr1 = 6'h16; wd1 = 8'h5A; req1 = 1'b1;
        cyc(10);
        chk("prst_no_en", en_cnt, 7);
        pe(1, 6'h16);
        pc(1, 1, 1, 8'h00);
        bus.READY = 1'b1;
        wait_drop(1, 100);
        chk("prst_en_cnt", en_cnt, 8);

        // RST_USB mid-init restarts at 0x04
        do_reset();
        pe(1, 6'h04); pe(0, 6'h04); pe(1, 6'h0A);
        push_nominal();
        cyc(5);
        bus.READY = 1'b1;
        begin
            int t = 0;
            while (en_cnt < 3 && t < 100) begin cyc(1); t++; end
            chk("mrst_en_wait", t < 100, 1);
        end
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mrst_init_done", INIT_DONE, 0);
        chk("mrst_en", bus.REG_EN, 0);
        wait_init("mrst_init_wait", 500);
        cyc(3);
        chk("mrst_done", INIT_DONE, 1);
        chk("mrst_en_cnt", en_cnt, 9);
        chk("mrst_q_empty", exp_en.size() + exp_cli.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
